// File: rtl/mpu_matrix_loader_if.sv
// ============================================================================
//  Module      : mpu_matrix_loader_if
//  Description : Bundles the command, element stream and operand handshake of
//                the MPU matrix loader into one interface.
//                  start/size        : command strobe and matrix order (1..5)
//                  in_data/in_valid  : row-major element stream into loader
//                  in_ready          : loader accepts an element this cycle
//                  matrix/size_out   : packed 5x5 operand and latched order
//                  out_valid/out_ready : operand handshake to operation unit
//                  busy/error        : status, error pulses on illegal size
//                The master modport drives the loader, the slave modport is
//                the loader itself.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mpu_matrix_loader_if;
  logic               start;
  logic signed [7:0]  size;
  logic signed [7:0]  in_data;
  logic               in_valid;
  logic               in_ready;
  logic        [0:199] matrix;
  logic signed [7:0]  size_out;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               error;

  modport master (
    output start, size, in_data, in_valid, out_ready,
    input  in_ready, matrix, size_out, out_valid, busy, error
  );

  modport slave (
    input  start, size, in_data, in_valid, out_ready,
    output in_ready, matrix, size_out, out_valid, busy, error
  );
endinterface

`default_nettype wire

// File: rtl/mpu_matrix_loader.sv
// ============================================================================
//  Module      : mpu_matrix_loader
//  Description : Operand-assembly front end of the matrix processing unit.
//                Accepts a command (order 1..5) and a row-major stream of
//                signed bytes, packs them into the 5x5 operand bus and holds
//                the result under a valid/ready handshake.
//  Ports       : clock   - rising-edge clock
//                reset_n - asynchronous active-low reset
//                bus     - mpu_matrix_loader_if.slave (command, element
//                          stream, packed operand, handshake, status)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mpu_matrix_loader (
  input  wire                      clock,
  input  wire                      reset_n,
  mpu_matrix_loader_if.slave       bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic        [0:199] r_matrix;
  logic signed [7:0]   r_size;
  logic        [2:0]   r_row;
  logic        [2:0]   r_col;
  logic                r_error;

  logic                w_size_legal;
  logic                w_cmd_ok;
  logic                w_accept;
  logic                w_last;
  logic        [2:0]   w_last_idx;
  logic        [4:0]   w_idx;
  logic        [7:0]   w_wr_base;
  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_busy;

  assign w_size_legal = (bus.size > 8'sd0) && (bus.size < 8'sd6);
  assign w_cmd_ok     = (r_state == ST_IDLE) && bus.start && w_size_legal;
  assign w_accept     = (r_state == ST_LOAD) && bus.in_valid;

  // r_size is 1..5 while loading, so its low three bits are the full order.
  assign w_last_idx   = r_size[2:0] - 3'd1;
  assign w_last       = (r_row == w_last_idx) && (r_col == w_last_idx);

  // Element (r,c) lives at byte 5r+c of the 5x5 bus regardless of the order.
  assign w_idx        = {r_row, 2'b00} + {2'b00, r_row} + {2'b00, r_col};
  assign w_wr_base    = {w_idx, 3'b000};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_busy       = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (w_cmd_ok) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_in_ready = 1'b1;
        if (w_accept && w_last) w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_next = ST_IDLE;
      end
      default: begin
        w_busy       = 1'b0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_matrix <= '0;
      r_size   <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_error  <= 1'b0;
    end else begin
      r_error <= (r_state == ST_IDLE) && bus.start && !w_size_legal;
      if (w_cmd_ok) begin
        // Clearing on every command keeps bytes outside the new order at 0.
        r_matrix <= '0;
        r_size   <= bus.size;
        r_row    <= '0;
        r_col    <= '0;
      end else if (w_accept) begin
        r_matrix[w_wr_base +: 8] <= bus.in_data;
        if (r_col == w_last_idx) begin
          r_col <= '0;
          // Row stays at order-1 after the final element so it never exceeds 4.
          if (!w_last) r_row <= r_row + 3'd1;
        end else begin
          r_col <= r_col + 3'd1;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.error     = r_error;
  assign bus.matrix    = r_matrix;
  assign bus.size_out  = r_size;

endmodule

`default_nettype wire
